button_debounce: RTL
====================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, minimum 2; the number of consecutive stable synchronized samples required to accept a level change.
REQ-002 SHALL have parameter LONG_CYCLES, default 1000000; the number of held cycles after acceptance at which a long press is flagged.
REQ-003 SHALL have parameter BTN_ACTIVE_LOW, default 0; when 1, i_btn is inverted before synchronization.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_btn, input, 1 bit: raw, asynchronous, bouncing push-button level.
REQ-007 SHALL have port o_btn, output, 1 bit: debounced level, registered; the clean button level fed to reset_sync i_rst.
REQ-008 SHALL have port o_press, output, 1 bit: one-cycle pulse on each accepted press.
REQ-009 SHALL have port o_release, output, 1 bit: one-cycle pulse on each accepted release.
REQ-010 SHALL have port o_long, output, 1 bit: one-cycle long-press pulse (see Configuration).

Function
REQ-011 i_btn (after optional inversion) SHALL pass through a 2-flop synchronizer; only the second flop output (s_btn) feeds logic.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED and RELEASE_WAIT, with one shared counter cnt.
REQ-013 IDLE: s_btn=1 -> PRESS_WAIT, cnt=1; else stay.
REQ-014 PRESS_WAIT: s_btn=0 -> IDLE, cnt=0 (bounce rejected, no pulse); s_btn=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, o_btn<=1, o_press=1 for one cycle, cnt=0; else cnt+1.
REQ-015 PRESSED: s_btn=0 -> RELEASE_WAIT, cnt=1; else stay.
REQ-016 RELEASE_WAIT: s_btn=1 -> PRESSED, cnt=0, no pulse; s_btn=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, o_btn<=0, o_release=1 for one cycle; else cnt+1.
REQ-017 Latency: with i_btn stable, o_btn SHALL change on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new i_btn level as edge 1.
REQ-018 o_press and o_release SHALL assert in the same cycle o_btn changes, and SHALL never assert together.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-020 cnt width SHALL be $clog2(max(DEBOUNCE_CYCLES,LONG_CYCLES)+1); cnt SHALL never wrap and SHALL saturate at its maximum.

Reset
REQ-021 i_rst_n=0 SHALL asynchronously clear the synchronizer flops, cnt and all outputs to 0, and SHALL set the state to IDLE.
REQ-022 Reset assertion mid-press SHALL emit no o_release; after deassertion a held button SHALL be re-debounced from IDLE.
REQ-023 Reset deassertion SHALL take effect on the next rising edge of i_clk.

Configuration
REQ-024 Macro DEBOUNCE_LONG_PRESS_EN defined: in PRESSED, cnt SHALL count held cycles, and o_long SHALL pulse once when cnt reaches LONG_CYCLES-1, then cnt SHALL saturate so there is at most one pulse per press.
REQ-025 Macro not defined: o_long SHALL be tied to 0, cnt width SHALL use DEBOUNCE_CYCLES only, and LONG_CYCLES SHALL be ignored.

Structure
REQ-026 Package debounce_pkg SHALL hold the state enum typedef (2-bit) and the counter-width function.
REQ-027 The 2-flop synchronizer SHALL be sub-module btn_sync (i_clk, i_rst_n, i_d, o_q), instantiated once.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, BTN_ACTIVE_LOW=0)
REQ-028 Clean press: i_btn 0->1 held -> o_btn=1 and o_press=1 on edge 6, o_press=0 on edge 7.
REQ-029 Bounce: i_btn pattern 1,0,1,1,0 then 0 held -> o_btn stays 0, no o_press.
REQ-030 Release with bounce: held press, then i_btn 0,1,0 held -> o_btn stays 1 through the bounce, then o_release on edge 6 after the final 0.
REQ-031 Long press with macro defined: held press -> o_long one-cycle pulse 10 cycles after o_press, no repeat; with macro undefined, o_long stays 0.
REQ-032 Reset mid-press: i_rst_n=0 while o_btn=1 -> all outputs 0 immediately and no o_release; after release of reset with button held, o_press re-fires on edge 6.

Source files
------------

// File: rtl/debounce_pkg.sv
// ============================================================================
// debounce_pkg
// Shared definitions for the push-button debouncer:
//   state_t    - 2-bit FSM state encoding (IDLE, PRESS_WAIT, PRESSED,
//                RELEASE_WAIT)
//   cnt_width  - width of the shared debounce / long-press counter
// No ports (package).
// ============================================================================
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // The counter must hold the largest terminal value it is compared
    // against. When long-press detection is disabled, only the debounce
    // length matters and the long-press length is ignored.
    function automatic int cnt_width(input int debounce_cycles,
                                     input int long_cycles,
                                     input bit long_en);
        int max_val;
        max_val = debounce_cycles;
        if (long_en && (long_cycles > debounce_cycles)) begin
            max_val = long_cycles;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// ============================================================================
// btn_sync
// Two-flop synchronizer bringing the raw, asynchronous button level into the
// i_clk domain. Both flops clear to 0 on reset.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input level
//   o_q     - synchronized level (second flop)
// ============================================================================
module btn_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    // First flop may go metastable; only the second flop is used downstream.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta <= 1'b0;
            o_q  <= 1'b0;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce
// Debounces a raw push-button level and produces a clean level plus
// one-cycle press / release pulses. Optional long-press detection is built
// when the macro DEBOUNCE_LONG_PRESS_EN is defined; otherwise o_long is
// tied to 0 and LONG_CYCLES has no effect.
// Parameters:
//   DEBOUNCE_CYCLES - stable synchronized samples to accept a change (>= 2)
//   LONG_CYCLES     - held cycles after acceptance that flag a long press
//   BTN_ACTIVE_LOW  - 1: invert i_btn before synchronization
// Ports:
//   i_clk     - clock, all state changes on the rising edge
//   i_rst_n   - asynchronous active-low reset
//   i_btn     - raw bouncing button level
//   o_btn     - registered debounced level
//   o_press   - one-cycle pulse on an accepted press
//   o_release - one-cycle pulse on an accepted release
//   o_long    - one-cycle long-press pulse (0 unless long press enabled)
// ============================================================================
module button_debounce
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1000000,
    parameter int BTN_ACTIVE_LOW  = 0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_btn,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, LONG_EN);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_DONE = CNT_W'(LONG_CYCLES);
`endif

    logic             btn_in;
    logic             s_btn;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign btn_in = (BTN_ACTIVE_LOW != 0) ? ~i_btn : i_btn;

    btn_sync u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (btn_in),
        .o_q     (s_btn)
    );

    // Saturating increment so the counter can never wrap.
    always_comb begin
        cnt_inc = cnt;
        if (cnt != {CNT_W{1'b1}}) begin
            cnt_inc = cnt + CNT_ONE;
        end
    end

`ifdef DEBOUNCE_LONG_PRESS_EN
    logic long_q;
    assign o_long = long_q;
`else
    assign o_long = 1'b0;
`endif

    // Debounce FSM. Pulses default low every cycle so each one lasts exactly
    // one clock. A bounce back to the old level during a wait state returns
    // to the stable state without any pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            o_btn     <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q    <= 1'b0;
`endif
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            long_q    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (s_btn) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s_btn) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= PRESSED;
                        o_btn   <= 1'b1;
                        o_press <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!s_btn) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
`ifdef DEBOUNCE_LONG_PRESS_EN
                    // Parking cnt past the terminal value guarantees a
                    // single long pulse per press.
                    else if (cnt == LONG_LAST) begin
                        long_q <= 1'b1;
                        cnt    <= LONG_DONE;
                    end else if (cnt < LONG_LAST) begin
                        cnt <= cnt_inc;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (s_btn) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state     <= IDLE;
                        o_btn     <= 1'b0;
                        o_release <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
